// File: rtl/alu_uart_pkg.sv
// Shared constants for the UART ALU command protocol: FSM encoding,
// byte slots of a request frame and the ALU op codes.
package alu_uart_pkg;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_LOAD     = 2'd1;
   localparam logic [1:0] ST_WAIT_TX  = 2'd2;
   localparam logic [1:0] ST_WAIT_RES = 2'd3;

   // wire order of a request frame
   localparam logic [1:0] IDX_A  = 2'd0;
   localparam logic [1:0] IDX_B  = 2'd1;
   localparam logic [1:0] IDX_OP = 2'd2;

   localparam logic [5:0] OP_ADD = 6'b100000;
   localparam logic [5:0] OP_SUB = 6'b100010;
   localparam logic [5:0] OP_AND = 6'b100100;
   localparam logic [5:0] OP_OR  = 6'b100101;
   localparam logic [5:0] OP_XOR = 6'b100110;
   localparam logic [5:0] OP_SRA = 6'b000011;
   localparam logic [5:0] OP_SRL = 6'b000010;
   localparam logic [5:0] OP_NOR = 6'b100111;

endpackage

// File: rtl/alu_uart_timeout.sv
// Response timer: saturating up-counter with clear, load and enable; o_tc
// marks the enabled cycle in which the count sits at TERM_CYC-1.
module alu_uart_timeout #(
   parameter int NB_COUNT = 24,
   parameter int TERM_CYC = 2000000
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_clear,
   input  logic                i_load,
   input  logic [NB_COUNT-1:0] i_load_val,
   input  logic                i_enable,
   output logic                o_tc
);

   localparam logic [NB_COUNT-1:0] C_TERM = NB_COUNT'(TERM_CYC - 1);
   localparam logic [NB_COUNT-1:0] C_MAX  = '1;

   logic [NB_COUNT-1:0] r_count;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_enable && (r_count != C_MAX)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_tc = i_enable && (r_count == C_TERM);

endmodule

// File: rtl/alu_uart_master.sv
// Host-side initiator for the UART ALU protocol: sends A, B, op as three
// bytes, then waits (bounded) for the single result byte.
//
// state       | meaning
// ------------+-----------------------------------------------------
// ST_IDLE     | ready for a request; frame buffer holds last request
// ST_LOAD     | o_tx_valid pulse for the byte selected by r_idx
// ST_WAIT_TX  | byte in flight, waiting for i_tx_done
// ST_WAIT_RES | all bytes sent, waiting for result byte or timeout
module alu_uart_master
   import alu_uart_pkg::*;
#(
   parameter int NB_DATA     = 8,
   parameter int NB_OPS      = 6,
   parameter int NB_TIMEOUT  = 24,
   parameter int TIMEOUT_CYC = 2000000
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_req_valid,
   output logic               o_req_ready,
   input  logic [NB_DATA-1:0] i_data_a,
   input  logic [NB_DATA-1:0] i_data_b,
   input  logic [NB_OPS-1:0]  i_ops,
   output logic [NB_DATA-1:0] o_tx_data,
   output logic               o_tx_valid,
   input  logic               i_tx_done,
   input  logic [NB_DATA-1:0] i_rx_data,
   input  logic               i_rx_valid,
   output logic [NB_DATA-1:0] o_res,
   output logic               o_res_valid,
   output logic               o_timeout
);

   if (64'(TIMEOUT_CYC) >= (64'd1 << NB_TIMEOUT)) begin : g_bad_timeout
      $error("TIMEOUT_CYC must be below 2**NB_TIMEOUT");
   end
   if (NB_OPS > NB_DATA) begin : g_bad_ops
      $error("NB_OPS must not exceed NB_DATA");
   end

   logic [1:0]         r_state;
   logic [1:0]         r_idx;
   logic [NB_DATA-1:0] r_buf_a;
   logic [NB_DATA-1:0] r_buf_b;
   logic [NB_DATA-1:0] r_buf_op;
   logic [NB_DATA-1:0] r_res;
   logic               r_res_valid;

   logic               w_accept;
   logic               w_last_byte;
   logic               w_tx_end;
   logic               w_timer_clr;
   logic               w_timer_en;
   logic               w_tc;
   logic [NB_DATA-1:0] w_tx_data;

   assign w_accept    = i_req_valid && (r_state == ST_IDLE);
   assign w_last_byte = (r_idx == IDX_OP);
   assign w_tx_end    = (r_state == ST_WAIT_TX) && i_tx_done;
   assign w_timer_clr = w_tx_end && w_last_byte;
   assign w_timer_en  = (r_state == ST_WAIT_RES);

   alu_uart_timeout #(
      .NB_COUNT (NB_TIMEOUT),
      .TERM_CYC (TIMEOUT_CYC)
   ) u_timeout (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_clear    (w_timer_clr),
      .i_load     (1'b0),
      .i_load_val ({NB_TIMEOUT{1'b0}}),
      .i_enable   (w_timer_en),
      .o_tc       (w_tc)
   );

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state     <= ST_IDLE;
         r_idx       <= IDX_A;
         r_buf_a     <= '0;
         r_buf_b     <= '0;
         r_buf_op    <= '0;
         r_res       <= '0;
         r_res_valid <= 1'b0;
      end else begin
         r_res_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_buf_a  <= i_data_a;
                  r_buf_b  <= i_data_b;
                  r_buf_op <= NB_DATA'(i_ops);
                  r_idx    <= IDX_A;
                  r_state  <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               r_state <= ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
               if (i_tx_done) begin
                  if (w_last_byte) begin
                     r_state <= ST_WAIT_RES;
                  end else begin
                     r_idx   <= r_idx + 2'd1;
                     r_state <= ST_LOAD;
                  end
               end
            end
            ST_WAIT_RES: begin
               // a result arriving on the terminal cycle beats the timeout
               if (i_rx_valid) begin
                  r_res       <= i_rx_data;
                  r_res_valid <= 1'b1;
                  r_state     <= ST_IDLE;
               end else if (w_tc) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // byte on the wire follows the index; stable through WAIT_TX
   always_comb begin
      w_tx_data = r_buf_op;
      case (r_idx)
         IDX_A:   w_tx_data = r_buf_a;
         IDX_B:   w_tx_data = r_buf_b;
         default: w_tx_data = r_buf_op;
      endcase
   end

   assign o_req_ready = (r_state == ST_IDLE);
   assign o_tx_valid  = (r_state == ST_LOAD);
   assign o_tx_data   = w_tx_data;
   assign o_res       = r_res;
   assign o_res_valid = r_res_valid;
   assign o_timeout   = (r_state == ST_WAIT_RES) && w_tc && !i_rx_valid;

endmodule

// File: tb/tb_alu_uart_master.sv
// Directed bench for alu_uart_master with a transaction-level model and a
// per-cycle compare process.
module tb_alu_uart_master;
   import alu_uart_pkg::*;

   localparam int TO = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [7:0] data_a = '0;
   logic [7:0] data_b = '0;
   logic [5:0] ops = '0;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_done = 1'b0;
   logic [7:0] rx_data = '0;
   logic       rx_valid = 1'b0;
   logic [7:0] res;
   logic       res_valid;
   logic       timeout;

   int n_checks = 0;
   int n_err = 0;
   int cnt_tx = 0;
   int cnt_res = 0;
   int cnt_to = 0;
   logic [7:0] tx_log[$];

   alu_uart_master #(
      .NB_DATA(8), .NB_OPS(6), .NB_TIMEOUT(24), .TIMEOUT_CYC(TO)
   ) dut (
      .i_clk(clk), .i_reset(rst),
      .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_data_a(data_a), .i_data_b(data_b), .i_ops(ops),
      .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_done(tx_done),
      .i_rx_data(rx_data), .i_rx_valid(rx_valid),
      .o_res(res), .o_res_valid(res_valid), .o_timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // transaction-level model: pending bytes, one byte in flight, bounded wait
   bit         m_busy, m_out, m_await, m_tx_v, m_res_v;
   int         m_wait;
   logic [7:0] m_q[$];
   logic [7:0] m_cur, m_res;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy = 0; m_out = 0; m_await = 0; m_tx_v = 0; m_res_v = 0;
         m_wait = 0; m_q.delete(); m_cur = '0; m_res = '0;
      end else begin
         m_tx_v = 0;
         m_res_v = 0;
         if (!m_busy && req_valid) begin
            m_busy = 1;
            m_q.delete();
            m_q.push_back(data_b);
            m_q.push_back({2'b00, ops});
            m_cur = data_a;
            m_tx_v = 1;
            m_out = 1;
         end else if (m_out && tx_done) begin
            m_out = 0;
            if (m_q.size() != 0) begin
               m_cur = m_q.pop_front();
               m_tx_v = 1;
               m_out = 1;
            end else begin
               m_await = 1;
               m_wait = 1;
            end
         end else if (m_await) begin
            if (rx_valid) begin
               m_res = rx_data; m_res_v = 1; m_await = 0; m_busy = 0;
            end else if (m_wait == TO) begin
               m_await = 0; m_busy = 0;
            end else begin
               m_wait++;
            end
         end
      end
   end

   always @(negedge clk) begin
      bit exp_to;
      exp_to = m_await && (m_wait == TO) && !rx_valid;
      check("req_ready", req_ready, !m_busy);
      check("tx_valid", tx_valid, m_tx_v);
      if (m_out) check("tx_data", tx_data, m_cur);
      check("res_valid", res_valid, m_res_v);
      check("res", res, m_res);
      check("timeout", timeout, exp_to);
      check("res_and_timeout", res_valid && timeout, 0);
      if (tx_valid === 1'b1) begin cnt_tx++; tx_log.push_back(tx_data); end
      if (res_valid === 1'b1) cnt_res++;
      if (timeout === 1'b1) cnt_to++;
   end

   task automatic wait_tx_valid();
      bit seen = 0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         seen = (tx_valid === 1'b1);
      end
      if (!seen) begin
         n_checks++; n_err++;
         $display("FAIL wait_tx_valid: no o_tx_valid within 60 cycles, got 0 expected 1");
      end
   endtask

   task automatic do_byte(input bit inj, input logic [7:0] inj_v);
      wait_tx_valid();
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         rx_valid = inj && (i == 3);
         rx_data  = inj_v;
      end
      tx_done = 1'b1;
      @(posedge clk); #1;
      tx_done = 1'b0;
   endtask

   task automatic send_req(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op, input bit keep);
      @(posedge clk); #1;
      req_valid = 1'b1; data_a = a; data_b = b; ops = op;
      @(posedge clk); #1;
      if (!keep) req_valid = 1'b0;
   endtask

   task automatic rx_byte(input logic [7:0] v);
      @(posedge clk); #1;
      rx_valid = 1'b1; rx_data = v;
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic check_log(input string name, input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
      logic [7:0] exp_b[3];
      exp_b[0] = e0; exp_b[1] = e1; exp_b[2] = e2;
      check({name, "_count"}, tx_log.size(), 3);
      for (int i = 0; i < 3; i++)
         check($sformatf("%s_byte%0d", name, i), (i < tx_log.size()) ? tx_log[i] : 8'hxx, exp_b[i]);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, r0, t0, x0;
      bit seen;

      #2 rst = 1'b1;
      #1;
      check("rst_ready", req_ready, 1);
      check("rst_tx_valid", tx_valid, 0);
      check("rst_tx_data", tx_data, 8'h00);
      check("rst_res", res, 8'h00);
      check("rst_res_valid", res_valid, 0);
      check("rst_timeout", timeout, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // basic transaction
      tx_log.delete(); r0 = cnt_res;
      send_req(8'h05, 8'h03, OP_ADD, 0);
      repeat (3) do_byte(0, 8'h00);
      repeat (2) @(posedge clk);
      rx_byte(8'h08);
      repeat (3) @(posedge clk); #1;
      check_log("t1_tx", 8'h05, 8'h03, 8'h20);
      check("t1_res", res, 8'h08);
      check("t1_res_pulses", cnt_res - r0, 1);
      check("t1_ready", req_ready, 1);

      // timeout without any response
      send_req(8'h01, 8'h02, OP_SUB, 0);
      repeat (3) do_byte(0, 8'h00);
      n = 0; seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         n++;
         seen = (timeout === 1'b1);
      end
      check("t2_timeout_cycle", n, TO);
      check("t2_res_kept", res, 8'h08);
      @(posedge clk); #1;
      check("t2_ready", req_ready, 1);

      // stray rx byte during WAIT_TX of byte B
      r0 = cnt_res;
      send_req(8'h0F, 8'h0E, OP_XOR, 0);
      do_byte(0, 8'h00);
      do_byte(1, 8'hAA);
      check("t3_stray_ignored", res, 8'h08);
      do_byte(0, 8'h00);
      rx_byte(8'hFF);
      repeat (2) @(posedge clk); #1;
      check("t3_res", res, 8'hFF);
      check("t3_res_pulses", cnt_res - r0, 1);

      // request held high while busy is not accepted
      tx_log.delete();
      send_req(8'h21, 8'h22, OP_AND, 1);
      data_a = 8'h11; data_b = 8'h12; ops = OP_OR;
      check("t4_busy_ready", req_ready, 0);
      repeat (3) do_byte(0, 8'h00);
      check_log("t4_first", 8'h21, 8'h22, 8'h24);
      rx_byte(8'h55);
      tx_log.delete();
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (3) do_byte(0, 8'h00);
      check_log("t4_second", 8'h11, 8'h12, 8'h25);
      rx_byte(8'h66);
      @(posedge clk); #1;
      check("t4_res", res, 8'h66);

      // reset while byte B is in flight
      send_req(8'h31, 8'h32, OP_SRA, 0);
      do_byte(0, 8'h00);
      wait_tx_valid();
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("t5_ready", req_ready, 1);
      check("t5_tx_valid", tx_valid, 0);
      check("t5_tx_data", tx_data, 8'h00);
      check("t5_res", res, 8'h00);
      check("t5_res_valid", res_valid, 0);
      check("t5_timeout", timeout, 0);
      @(posedge clk); #1 rst = 1'b0;
      x0 = cnt_tx; r0 = cnt_res; t0 = cnt_to;
      @(posedge clk); #1 tx_done = 1'b1;
      @(posedge clk); #1 tx_done = 1'b0;
      repeat (30) @(posedge clk); #1;
      check("t5_no_tx_after", cnt_tx - x0, 0);
      check("t5_no_res_after", (cnt_res - r0) + (cnt_to - t0), 0);
      check("t5_ready_after", req_ready, 1);

      // result on the exact timeout cycle wins
      r0 = cnt_res; t0 = cnt_to;
      send_req(8'h41, 8'h42, OP_NOR, 0);
      repeat (3) do_byte(0, 8'h00);
      repeat (TO - 2) @(posedge clk);
      rx_byte(8'h3C);
      repeat (3) @(posedge clk); #1;
      check("t6_res", res, 8'h3C);
      check("t6_res_pulses", cnt_res - r0, 1);
      check("t6_no_timeout", cnt_to - t0, 0);
      check("t6_ready", req_ready, 1);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
